jk_bank_sequencer: RTL and testbench

//  Owns a WIDTH-bit bank of JK flip-flop cells and sequences their J/K inputs from a command stream.

---
 rtl/jk_seq_pkg.sv | 15 +
 rtl/jk_bank_sequencer_if.sv | 23 ++
 rtl/jk_cell.sv | 24 ++
 rtl/jk_bank_sequencer.sv | 118 +++++++++++
 tb/tb_jk_bank_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/jk_seq_pkg.sv
// Shared opcode and FSM state encodings for the JK bank sequencer.
package jk_seq_pkg;
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SET  = 3'b001;
    localparam logic [2:0] OP_CLR  = 3'b010;
    localparam logic [2:0] OP_TGL  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_CNTU = 3'b101;
    localparam logic [2:0] OP_CNTD = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command channel into the JK bank sequencer: valid/ready handshake, command fields and abort.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int REPW  = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] cmd_data;
    logic [REPW-1:0]  cmd_rep;
    logic             abort;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_rep, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_rep, abort,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with synchronous active-high reset and complementary output.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;
endmodule

// File: rtl/jk_bank_sequencer.sv
// Sequences J/K patterns into a WIDTH-bit JK bank for cmd_rep+1 clocks per accepted command.
// One command in flight; cmd_ready only in IDLE, done/aborted pulse one cycle after the last update.
import jk_seq_pkg::*;

module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int REPW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    jk_bank_sequencer_if.slave cmd,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qbar,
    output logic [WIDTH-1:0]  j_vec,
    output logic [WIDTH-1:0]  k_vec,
    output logic              done,
    output logic              aborted
);
    logic [1:0]       state;
    logic [REPW-1:0]  cnt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] data_r;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign done          = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_r    <= OP_HOLD;
            mask_r  <= '0;
            data_r  <= '0;
            aborted <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    aborted <= 1'b0;
                    if (cmd.cmd_valid) begin
                        state  <= ST_EXEC;
                        cnt    <= cmd.cmd_rep;
                        op_r   <= cmd.cmd_op;
                        mask_r <= cmd.cmd_mask;
                        data_r <= cmd.cmd_data;
                    end
                end
                ST_EXEC: begin
                    // The update on this edge always happens; abort only cuts the remaining ones.
                    if (cnt == '0 || cmd.abort) begin
                        state   <= ST_DONE;
                        aborted <= cmd.abort;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    aborted <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        logic carry;
        j_vec = '0;
        k_vec = '0;
        carry = 1'b1;
        if (state == ST_EXEC) begin
            case (op_r)
                OP_SET: j_vec = mask_r;
                OP_CLR: k_vec = mask_r;
                OP_TGL: begin
                    j_vec = mask_r;
                    k_vec = mask_r;
                end
                OP_LOAD: begin
                    j_vec = data_r;
                    k_vec = ~data_r;
                end
                OP_CNTU: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j_vec[i] = carry;
                        carry    = carry & q[i];
                    end
                    k_vec = j_vec;
                end
                OP_CNTD: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j_vec[i] = carry;
                        carry    = carry & ~q[i];
                    end
                    k_vec = j_vec;
                end
                OP_SHL: begin
                    j_vec = {q[WIDTH-2:0], data_r[0]};
                    k_vec = ~j_vec;
                end
                default: begin
                    j_vec = '0;
                    k_vec = '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .j    (j_vec[gi]),
            .k    (k_vec[gi]),
            .q    (q[gi]),
            .qbar (qbar[gi])
        );
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench: driver pushes expected end-of-command results, negedge monitor checks done pulses.
module tb_jk_bank_sequencer;
    localparam int W = 8;
    localparam int R = 4;

    typedef struct {
        logic [W-1:0] q;
        logic         ab;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] q, qbar, j_vec, k_vec;
    logic         done, aborted;

    jk_bank_sequencer_if #(.WIDTH(W), .REPW(R)) cif ();

    jk_bank_sequencer #(.WIDTH(W), .REPW(R)) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cif.slave),
        .q       (q),
        .qbar    (qbar),
        .j_vec   (j_vec),
        .k_vec   (k_vec),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     exp_dones = 0;
    int     seen_dones = 0;
    exp_t   sb[$];
    logic [W-1:0] mq = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Behavioural effect of one update on the whole register, as plain arithmetic.
    function automatic logic [W-1:0] step(input logic [2:0] op, input logic [W-1:0] cur,
                                          input logic [W-1:0] m, input logic [W-1:0] d);
        case (op)
            3'd1:    return cur | m;
            3'd2:    return cur & ~m;
            3'd3:    return cur ^ m;
            3'd4:    return d;
            3'd5:    return cur + 8'd1;
            3'd6:    return cur - 8'd1;
            3'd7:    return {cur[W-2:0], d[0]};
            default: return cur;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("qbar", {24'd0, qbar}, {24'd0, ~q});
            if (cif.cmd_ready) begin
                check("idle_j", {24'd0, j_vec}, 32'd0);
                check("idle_k", {24'd0, k_vec}, 32'd0);
            end
            if (done) begin
                seen_dones++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_q", {24'd0, q}, {24'd0, e.q});
                    check("done_aborted", {31'd0, aborted}, {31'd0, e.ab});
                end
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!cif.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cif.cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] m, input logic [W-1:0] d,
                         input logic [R-1:0] rep, input int ab, input bit push, input bit hold);
        int n;
        bit is_ab;
        wait_ready();
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_mask  = m;
        cif.cmd_data  = d;
        cif.cmd_rep   = rep;
        @(posedge clk);
        if (push) begin
            is_ab = (ab >= 0) && (ab <= int'(rep));
            n = is_ab ? ab + 1 : int'(rep) + 1;
            for (int i = 0; i < n; i++) mq = step(op, mq, m, d);
            sb.push_back('{q: mq, ab: is_ab});
            exp_dones++;
        end
        @(negedge clk);
        if (!hold) cif.cmd_valid = 1'b0;
    endtask

    task automatic abort_after(input int a);
        repeat (a) @(negedge clk);
        cif.abort = 1'b1;
        @(negedge clk);
        cif.abort = 1'b0;
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = '0;
        cif.cmd_mask  = '0;
        cif.cmd_data  = '0;
        cif.cmd_rep   = '0;
        cif.abort     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_qbar", {24'd0, qbar}, 32'hFF);
        check("rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_jk", {16'd0, j_vec, k_vec}, 32'd0);

        // LOAD timing: update on first edge after accept, done that cycle, ready one later.
        issue(3'd4, 8'h00, 8'hA5, 4'd0, -1, 1'b1, 1'b0);
        check("load_pre_q", {24'd0, q}, 32'h00);
        @(negedge clk);
        check("load_q", {24'd0, q}, 32'hA5);
        check("load_done", {31'd0, done}, 32'd1);
        check("load_busy", {31'd0, cif.cmd_ready}, 32'd0);
        @(negedge clk);
        check("load_ready", {31'd0, cif.cmd_ready}, 32'd1);
        check("load_done_fall", {31'd0, done}, 32'd0);

        issue(3'd4, 8'h00, 8'h33, 4'd0, -1, 1'b1, 1'b0);
        issue(3'd3, 8'h0F, 8'h00, 4'd0, -1, 1'b1, 1'b0);
        issue(3'd1, 8'hC0, 8'h00, 4'd0, -1, 1'b1, 1'b0);
        issue(3'd2, 8'h0C, 8'h00, 4'd0, -1, 1'b1, 1'b0);

        // Count up across the wrap, checking each intermediate value.
        issue(3'd4, 8'h00, 8'hFE, 4'd0, -1, 1'b1, 1'b0);
        issue(3'd5, 8'h00, 8'h00, 4'd2, -1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] e;
            e = 8'hFE + 8'(i + 1);
            @(negedge clk);
            check("cntu_seq", {24'd0, q}, {24'd0, e});
        end

        issue(3'd4, 8'h00, 8'h02, 4'd0, -1, 1'b1, 1'b0);
        issue(3'd6, 8'h00, 8'h00, 4'd9, 2, 1'b1, 1'b0);
        abort_after(2);

        // Abort exactly on the last update still reports aborted.
        issue(3'd7, 8'h00, 8'h01, 4'd3, 3, 1'b1, 1'b0);
        abort_after(3);

        // Maximum repeat count: 16 updates.
        issue(3'd5, 8'h00, 8'h00, 4'd15, -1, 1'b1, 1'b0);

        // Valid held high with changing fields while busy must not re-latch or re-accept.
        issue(3'd1, 8'h01, 8'h00, 4'd3, -1, 1'b1, 1'b1);
        cif.cmd_op   = 3'd4;
        cif.cmd_data = 8'hFF;
        repeat (3) @(negedge clk);
        cif.cmd_valid = 1'b0;

        // Reset mid-command: bank clears, no done pulse follows.
        issue(3'd5, 8'h00, 8'h00, 4'd15, -1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cif.cmd_valid = 1'b0;
        mq = '0;
        check("rstmid_q", {24'd0, q}, 32'h00);
        check("rstmid_ready", {31'd0, cif.cmd_ready}, 32'd1);
        check("rstmid_done", {31'd0, done}, 32'd0);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   op;
            logic [R-1:0] rep;
            int           ab;
            op  = 3'($urandom_range(0, 7));
            rep = R'($urandom_range(0, 15));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rep) + 2)) : -1;
            issue(op, 8'($urandom), 8'($urandom), rep, ab, 1'b1, 1'b0);
            if (ab >= 0) abort_after(ab);
        end

        wait_ready();
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        check("done_count", seen_dones, exp_dones);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
